// File: rtl/sig_frame_prefetch.sv
// sig_frame_prefetch
// Fetches one frame's calibration words and ECG/EMG samples from the shared
// signal memory into the scope line buffers. The fetch starts on each
// vertical-blanking pulse. Only one read is outstanding at a time.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   frame_start          one-cycle pulse that starts a frame fetch
//   mem_req/mem_addr     read request and address to the memory arbiter
//   mem_gnt              grant; the address is accepted on req & gnt
//   mem_rdata            read data, valid one cycle after acceptance
//   buf_we/buf_sel/      line-buffer write strobe, buffer select (0 ECG,
//   buf_waddr/buf_wdata  1 EMG), sample index and 12-bit sample
//   min_*/max_*          calibration set, published atomically per frame
//   busy                 transfer in progress
//   frame_ready          one-cycle pulse with the final buffer write
//   overrun              sticky: frame_start arrived while busy
module sig_frame_prefetch #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int CAL_BASE = 1705,
  parameter int ECG_BASE = 12'h559,
  parameter int EMG_BASE = 12'h6AD,
  parameter int SAMPLES  = 320
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              buf_we,
  output logic              buf_sel,
  output logic [8:0]        buf_waddr,
  output logic [11:0]       buf_wdata,
  output logic [11:0]       min_ecg,
  output logic [11:0]       min_emg,
  output logic [11:0]       max_ecg,
  output logic [11:0]       max_emg,
  output logic              busy,
  output logic              frame_ready,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Phase boundaries of the word counter: 4 calibration words, then the
  // ECG samples, then the EMG samples.
  localparam logic [9:0] K_ECG  = 10'd4;
  localparam logic [9:0] K_EMG  = 10'(4 + SAMPLES);
  localparam logic [9:0] K_LAST = 10'(4 + 2 * SAMPLES - 1);

  localparam logic [ADDR_W-1:0] CAL_A = ADDR_W'(CAL_BASE);
  localparam logic [ADDR_W-1:0] ECG_A = ADDR_W'(ECG_BASE);
  localparam logic [ADDR_W-1:0] EMG_A = ADDR_W'(EMG_BASE);

  state_t            state;
  state_t            next_state;
  logic [9:0]        k;
  logic [ADDR_W-1:0] k_addr;
  logic [11:0]       rdata_lo;
  logic [DATA_W-13:0] unused_rdata_hi;
  logic [11:0]       sh_min_ecg, sh_min_emg, sh_max_ecg, sh_max_emg;

  assign k_addr          = ADDR_W'(k);
  assign rdata_lo        = mem_rdata[11:0];
  assign unused_rdata_hi = mem_rdata[DATA_W-1:12];

  assign busy    = (state != IDLE);
  assign mem_req = (state == REQ);

  // The address is a pure function of the counter, so it cannot move while
  // a request sits waiting for its grant.
  always_comb begin
    mem_addr = '0;
    if (state == REQ) begin
      if (k < K_ECG)
        mem_addr = CAL_A + k_addr;
      else if (k < K_EMG)
        mem_addr = ECG_A + k_addr - ADDR_W'(K_ECG);
      else
        mem_addr = EMG_A + k_addr - ADDR_W'(K_EMG);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (frame_start) next_state = REQ;
      REQ:  if (mem_gnt) next_state = WAIT;
      WAIT: next_state = (k == K_LAST) ? DONE : REQ;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Datapath. Calibration words land in shadow registers and only reach the
  // outputs together on the final-write edge, so the renderer never sees a
  // half-updated set.
  always_ff @(posedge clock) begin
    if (reset) begin
      k           <= '0;
      buf_we      <= 1'b0;
      buf_sel     <= 1'b0;
      buf_waddr   <= '0;
      buf_wdata   <= '0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      sh_min_ecg  <= 12'd0;
      sh_min_emg  <= 12'd0;
      sh_max_ecg  <= 12'hFFF;
      sh_max_emg  <= 12'hFFF;
      min_ecg     <= 12'd0;
      min_emg     <= 12'd0;
      max_ecg     <= 12'hFFF;
      max_emg     <= 12'hFFF;
    end else begin
      buf_we      <= 1'b0;
      frame_ready <= 1'b0;
      if (frame_start && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: if (frame_start) k <= '0;
        WAIT: begin
          if (k < K_ECG) begin
            case (k[1:0])
              2'd0:    sh_min_ecg <= rdata_lo;
              2'd1:    sh_min_emg <= rdata_lo;
              2'd2:    sh_max_ecg <= rdata_lo;
              default: sh_max_emg <= rdata_lo;
            endcase
          end else begin
            buf_we    <= 1'b1;
            buf_sel   <= (k >= K_EMG);
            buf_waddr <= (k >= K_EMG) ? 9'(k - K_EMG) : 9'(k - K_ECG);
            buf_wdata <= rdata_lo;
          end
          if (k == K_LAST) begin
            frame_ready <= 1'b1;
            min_ecg     <= sh_min_ecg;
            min_emg     <= sh_min_emg;
            max_ecg     <= sh_max_ecg;
            max_emg     <= sh_max_emg;
          end else begin
            k <= k + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_frame_prefetch.sv
// Testbench for sig_frame_prefetch: memory model returning the address (or
// fixed calibration words), a negedge monitor that records the frame's
// transactions, a vector table of frame scenarios and a few hand sequences.
module tb_sig_frame_prefetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        buf_we, buf_sel;
  logic [8:0]  buf_waddr;
  logic [11:0] buf_wdata;
  logic [11:0] min_ecg, min_emg, max_ecg, max_emg;
  logic        busy, frame_ready, overrun;

  sig_frame_prefetch dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .buf_we(buf_we), .buf_sel(buf_sel),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .min_ecg(min_ecg), .min_emg(min_emg), .max_ecg(max_ecg), .max_emg(max_emg),
    .busy(busy), .frame_ready(frame_ready), .overrun(overrun)
  );

  always #5 clock = ~clock;

  localparam logic [47:0] CAL_RESET = {12'd0, 12'd0, 12'd4095, 12'd4095};
  localparam logic [47:0] CAL_WORDS = {12'd10, 12'd20, 12'd4000, 12'd3000};
  localparam logic [47:0] CAL_ADDRS = {12'd1705, 12'd1706, 12'd1707, 12'd1708};

  int          tests = 0;
  int          failures = 0;
  int          gnt_pct = 100;
  bit          cal_mode = 1'b0;
  logic [31:0] upper = '0;

  wire [47:0] cal = {min_ecg, min_emg, max_ecg, max_emg};

  // Memory model: word = address, optionally with calibration overrides and
  // junk in the upper bits.
  function automatic logic [31:0] mem_val(input logic [11:0] a);
    logic [11:0] v;
    v = a;
    if (cal_mode) begin
      case (a)
        12'd1705: v = 12'd10;
        12'd1706: v = 12'd20;
        12'd1707: v = 12'd4000;
        12'd1708: v = 12'd3000;
        default:  ;
      endcase
    end
    return upper | {20'h0, v};
  endfunction

  always @(posedge clock) begin
    if (mem_req && mem_gnt) mem_rdata <= mem_val(mem_addr);
    else                    mem_rdata <= 32'hA5A5_A5A5;
  end

  always @(posedge clock) begin
    #1;
    mem_gnt = (int'($urandom_range(0, 99)) < gnt_pct);
  end

  // Monitor: cycle 0 is the cycle in which an accepted frame_start is high.
  int          cyc = 0;
  int          acc, we_cnt, ready_cnt, ready_cyc, last_we_cyc, busy_low_cyc;
  int          first_req_cyc, stall_err, glitch, bad_waddr;
  logic [11:0] first_addr;
  logic [15:0] ecg_buf [320];
  logic [15:0] emg_buf [320];
  logic [47:0] last_cal = '0;
  logic [47:0] pre_cal;
  logic        last_stall = 1'b0;
  logic        last_reset = 1'b0;
  logic [11:0] last_addr = '0;

  always @(negedge clock) begin
    if (frame_start && !busy && !reset) begin
      cyc = 0; acc = 0; we_cnt = 0; ready_cnt = 0; ready_cyc = -1;
      last_we_cyc = -1; busy_low_cyc = -1; first_req_cyc = -1;
      stall_err = 0; glitch = 0; bad_waddr = 0; first_addr = '0; pre_cal = '0;
      for (int i = 0; i < 320; i++) begin
        ecg_buf[i] = 16'hFFFF;
        emg_buf[i] = 16'hFFFF;
      end
    end else begin
      cyc++;
    end
    if (mem_req && first_req_cyc < 0) begin
      first_req_cyc = cyc;
      first_addr = mem_addr;
    end
    if (mem_req && mem_gnt) acc++;
    if (last_stall && !last_reset && (!mem_req || mem_addr != last_addr)) stall_err++;
    if (buf_we) begin
      we_cnt++;
      last_we_cyc = cyc;
      if (buf_waddr >= 9'd320) bad_waddr++;
      else if (buf_sel) emg_buf[buf_waddr] = {4'h0, buf_wdata};
      else ecg_buf[buf_waddr] = {4'h0, buf_wdata};
    end
    if (frame_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
      pre_cal = last_cal;
    end else if (cal !== last_cal && !last_reset) begin
      glitch++;
    end
    if (ready_cnt > 0 && busy_low_cyc < 0 && !busy) busy_low_cyc = cyc;
    last_cal = cal;
    last_stall = mem_req && !mem_gnt;
    last_addr = mem_addr;
    last_reset = reset;
  end

  typedef struct {
    string       name;
    int          gnt_pct;
    bit          cal_mode;
    logic [31:0] upper;
    int          repulse;
    int          exp_ready;
    logic [47:0] exp_cal;
    bit          exp_overrun;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge clock); #1;
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
  endtask

  // Returns one cycle after the monitor reports cycle 'target', i.e. the
  // caller is then inside cycle target+1.
  task automatic wait_cycle(input int target);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 5000 && !hit; n++) begin
      @(posedge clock); #1;
      if (cyc == target) hit = 1'b1;
    end
    if (!hit) checkOutput("wait_cycle_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 20000 && !hit; n++) begin
      @(posedge clock); #1;
      if (ready_cnt > 0 && busy_low_cyc >= 0) hit = 1'b1;
    end
    if (!hit) checkOutput("frame_timeout", 0, 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    applyReset();
    gnt_pct = v.gnt_pct;
    cal_mode = v.cal_mode;
    upper = v.upper;
    start_frame();
    if (v.repulse > 0) begin
      wait_cycle(v.repulse - 1);
      frame_start = 1'b1;
      @(posedge clock); #1;
      frame_start = 1'b0;
    end
    wait_done();
  endtask

  task automatic check_buffers(input string name);
    int bad;
    logic [11:0] e;
    bad = 0;
    for (int i = 0; i < 320; i++) begin
      e = 12'h559 + 12'(i);
      if (ecg_buf[i] !== {4'h0, e}) bad++;
      e = 12'h6AD + 12'(i);
      if (emg_buf[i] !== {4'h0, e}) bad++;
    end
    checkOutput({name, "_buf_errors"}, bad, 0);
    checkOutput({name, "_ecg0"}, ecg_buf[0], 16'h0559);
    checkOutput({name, "_emg319"}, emg_buf[319], 16'h07EC);
  endtask

  initial begin
    vecs[0] = '{"gnt1_addr",  100, 1'b0, 32'h0,        0,   1289, CAL_ADDRS, 1'b0};
    vecs[1] = '{"gnt1_cal",   100, 1'b1, 32'h0,        0,   1289, CAL_WORDS, 1'b0};
    vecs[2] = '{"gnt30_cal",  30,  1'b1, 32'h0,        0,   -1,   CAL_WORDS, 1'b0};
    vecs[3] = '{"upper_bits", 100, 1'b1, 32'hFFFFF000, 0,   1289, CAL_WORDS, 1'b0};
    vecs[4] = '{"repulse500", 100, 1'b0, 32'h0,        500, 1289, CAL_ADDRS, 1'b1};

    applyReset();
    @(negedge clock);
    checkOutput("reset_ctrl",
                {mem_req, mem_addr, buf_we, buf_sel, buf_waddr, buf_wdata, busy, frame_ready, overrun},
                39'd0);
    checkOutput("reset_cal", cal, CAL_RESET);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_accepted"}, acc, 644);
      checkOutput({vecs[i].name, "_we_pulses"}, we_cnt, 640);
      checkOutput({vecs[i].name, "_ready_pulses"}, ready_cnt, 1);
      checkOutput({vecs[i].name, "_first_req_cyc"}, first_req_cyc, 1);
      checkOutput({vecs[i].name, "_first_addr"}, first_addr, 12'd1705);
      checkOutput({vecs[i].name, "_stall_err"}, stall_err, 0);
      checkOutput({vecs[i].name, "_bad_waddr"}, bad_waddr, 0);
      checkOutput({vecs[i].name, "_cal_glitch"}, glitch, 0);
      checkOutput({vecs[i].name, "_cal_before"}, pre_cal, CAL_RESET);
      checkOutput({vecs[i].name, "_cal_after"}, cal, vecs[i].exp_cal);
      checkOutput({vecs[i].name, "_overrun"}, overrun, vecs[i].exp_overrun);
      checkOutput({vecs[i].name, "_busy_idle"}, busy, 1'b0);
      if (vecs[i].exp_ready >= 0) begin
        checkOutput({vecs[i].name, "_ready_cyc"}, ready_cyc, vecs[i].exp_ready);
        checkOutput({vecs[i].name, "_last_we_cyc"}, last_we_cyc, vecs[i].exp_ready);
        checkOutput({vecs[i].name, "_busy_low_cyc"}, busy_low_cyc, vecs[i].exp_ready + 1);
      end
      check_buffers(vecs[i].name);
    end

    // Overrun stays set and a fresh frame_start after completion runs normally.
    start_frame();
    wait_done();
    checkOutput("after_overrun_accepted", acc, 644);
    checkOutput("after_overrun_ready_cyc", ready_cyc, 1289);
    checkOutput("after_overrun_sticky", overrun, 1'b1);
    check_buffers("after_overrun");

    // Published calibration persists into the next frame, then reset at
    // cycle 700 clears everything and a new frame completes.
    applyReset();
    gnt_pct = 100;
    cal_mode = 1'b1;
    upper = '0;
    start_frame();
    wait_done();
    checkOutput("persist_first_cal", cal, CAL_WORDS);
    cal_mode = 1'b0;
    start_frame();
    wait_cycle(699);
    checkOutput("persist_mid_frame", cal, CAL_WORDS);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midreset_ctrl", {mem_req, buf_we, busy, frame_ready}, 4'b0000);
    checkOutput("midreset_cal", cal, CAL_RESET);
    start_frame();
    wait_done();
    checkOutput("post_reset_accepted", acc, 644);
    checkOutput("post_reset_ready_cyc", ready_cyc, 1289);
    checkOutput("post_reset_cal", cal, CAL_ADDRS);
    checkOutput("post_reset_overrun", overrun, 1'b0);
    check_buffers("post_reset");

    // frame_start in the same cycle as frame_ready is ignored but flagged.
    applyReset();
    start_frame();
    wait_cycle(1288);
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("coincident_ready_cyc", ready_cyc, 1289);
    checkOutput("coincident_overrun", overrun, 1'b1);
    checkOutput("coincident_busy", busy, 1'b0);
    checkOutput("coincident_accepted", acc, 644);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/sig_frame_prefetch.md
Name: sig_frame_prefetch

Overview:
Controller that sequences the per-frame fetch of ECG/EMG waveform samples and calibration words from the shared signal memory into the display line buffers. It is triggered once per frame at vertical blanking and arbitrates for the memory read port with a req/grant handshake, so the CPU side keeps priority. It feeds the scope renderer with two 320-entry sample buffers and an atomically published set of min/max calibration values.

Parameters:
ADDR_W, 12, signal memory address width
DATA_W, 32, signal memory data width
CAL_BASE, 1705, address of calibration words in order min_ecg, min_emg, max_ecg, max_emg
ECG_BASE, 12'h559, first ECG sample address
EMG_BASE, 12'h6AD, first EMG sample address
SAMPLES, 320, samples per channel per frame

Ports:
clock  in  1  system clock (100 MHz); all logic on rising edge
reset  in  1  synchronous, active-high
frame_start  in  1  one-cycle pulse at start of vertical blanking
mem_req  out  1  read request to signal memory arbiter
mem_addr  out  ADDR_W  read address, valid while mem_req high
mem_gnt  in  1  grant; address accepted on cycle with mem_req&mem_gnt
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after accepted request
buf_we  out  1  line-buffer write strobe
buf_sel  out  1  0 = ECG buffer, 1 = EMG buffer
buf_waddr  out  9  sample index 0..SAMPLES-1
buf_wdata  out  12  mem_rdata[11:0]
min_ecg, min_emg, max_ecg, max_emg  out  12 each  published calibration
busy  out  1  transfer in progress
frame_ready  out  1  one-cycle pulse: buffers and calibration complete
overrun  out  1  sticky: frame_start received while busy

Behaviour:
- Reset values: mem_req 0, mem_addr 0, buf_we 0, buf_sel 0, buf_waddr 0, buf_wdata 0, busy 0, frame_ready 0, overrun 0, min_* 0, max_* 4095; FSM to IDLE; shadow cal regs cleared to same values.
- States: IDLE, REQ, WAIT, DONE. Phase counter k = 0..643: k 0-3 calibration, 4-323 ECG, 324-643 EMG.
- IDLE: frame_start -> REQ, k=0, busy=1 next cycle.
- REQ: mem_req=1, mem_addr = CAL_BASE+k / ECG_BASE+(k-4) / EMG_BASE+(k-324); held stable until mem_gnt. On mem_req&mem_gnt -> WAIT, mem_req drops next cycle. Only one outstanding read.
- WAIT: capture mem_rdata. Cal phase: mem_rdata[11:0] into shadow reg k, no buf_we. Sample phase: registered buf_we=1 next cycle with buf_sel, buf_waddr=k-4 or k-324, buf_wdata=mem_rdata[11:0]. If k<643 -> REQ with k+1; else -> DONE.
- Throughput with mem_gnt tied high: 2 cycles/word; frame_start at cycle 0 -> first mem_req cycle 1, word k accepted at 1+2k, written at 3+2k; final buf_we at cycle 1289.
- DONE: frame_ready pulse coincides with final buf_we; shadow cal copied to min_*/max_* on that same edge (all four change together, never partially); busy low next cycle, -> IDLE.
- Grant stall: mem_req/mem_addr held indefinitely; no timeout.
- frame_start while busy: ignored for sequencing, overrun set (cleared only by reset). frame_start in the same cycle as frame_ready: ignored, overrun set.
- Reset mid-transfer: mem_req and buf_we drop the following edge; published cal returns to reset values; in-flight read data discarded.
- Published cal values persist across frames until the next completed transfer.

Test Plan:
- mem_gnt=1, memory[a]=a; frame_start at cycle 0 -> 644 accepted reads, first addr 1705, ECG buf[0]=0x559, EMG buf[319]=0x6AD+319=0x7EC, frame_ready at cycle 1289 only, busy low at 1290.
- Calibration words 1705..1708 = 10,20,4000,3000 -> min_ecg=10, min_emg=20, max_ecg=4000, max_emg=3000, all changing on the frame_ready edge; before that still 0/4095.
- mem_gnt random 30% duty -> mem_addr stable during every stalled request, buffer contents identical to gnt=1 run, exactly 640 buf_we pulses.
- frame_start re-pulsed at cycle 500 -> transfer unaffected, overrun=1 and stays 1; second frame_start after completion starts new transfer normally.
- reset asserted at cycle 700 -> next cycle mem_req=0, buf_we=0, busy=0, min_*=0, max_*=4095; new frame_start completes a full transfer.
- mem_rdata upper bits 0xFFFFF000 set -> buf_wdata and cal outputs carry only bits [11:0].
